v1_filter_trigger_ctrl: RTL and testbench
=========================================

Name: v1_filter_trigger_ctrl

Overview:
- Event controller behind the v1 trapezoidal shaping filter; consumes one signed filter sample per clk.
- Arms on a threshold crossing, tracks the pulse peak over a fixed window, and flags pile-up.
- Emits one event record (amplitude, timestamp, pile-up) over a valid/ready handshake, then enforces a dead time before re-arming.
- Sits between the filter output and the event FIFO/readout logic.

Parameters:
- PEAK_WIN, 16, samples in the peak-search window, crossing sample included; legal range 2..255
- DEAD_TIME, 32, clk cycles of dead time after the event handshake; legal range 1..1023
- TS_W, 32, timestamp counter width
- LOST_W, 16, lost-trigger counter width

Ports:
- reset  in  1  asynchronous, active-low reset
- clk  in  1  clock
- enable  in  1  arm request; low returns the block to IDLE from ARMED only
- threshold  in  SIZE_FILTER_DATA  signed trigger level; sampled every cycle
- filter_data  in  SIZE_FILTER_DATA  signed filter output, valid every cycle
- event_valid  out  1  event record valid
- event_ready  in  1  consumer accepts the record
- event_amp  out  SIZE_FILTER_DATA  signed peak amplitude
- event_ts  out  TS_W  timestamp of the crossing sample
- event_pileup  out  1  pile-up detected inside the window
- busy  out  1  high in PEAK, HOLD or DEAD
- lost_count  out  LOST_W  saturating count of crossings missed in HOLD or DEAD

Behaviour:
- Reset values: all outputs 0; state IDLE; ts counter 0; prev sample 0.
- Timestamp: free-running ts counter, +1 per clk, wraps modulo 2^TS_W.
- Crossing (rise): filter_data > threshold AND prev_sample <= threshold, both signed compares. prev_sample is filter_data registered.
- IDLE: go to ARMED when enable=1.
- ARMED:
  - enable=0 -> IDLE.
  - On rise -> PEAK: max = filter_data, ts_cap = ts counter this cycle, win_cnt = 1, pileup = 0, below = 0.
  - A rise and enable=0 in the same cycle: the rise wins.
- PEAK: each cycle, in order:
  - If filter_data > max, update max.
  - If filter_data <= threshold, set below.
  - If below was already set and a rise occurs, set pileup.
  - win_cnt++.
  - When win_cnt reaches PEAK_WIN, go to HOLD at the next edge. event_valid asserts exactly PEAK_WIN cycles after the crossing cycle.
- HOLD:
  - event_valid=1; event_amp/event_ts/event_pileup are stable and held while valid=1 and ready=0.
  - Transfer occurs on valid & ready. Next cycle: event_valid=0, go to DEAD, dead_cnt = DEAD_TIME.
  - event_ready is ignored while event_valid=0.
- DEAD: dead_cnt-- each cycle; at dead_cnt reaching 0, go to ARMED if enable=1, else IDLE.
- Lost triggers: each rise seen in HOLD or DEAD increments lost_count, saturating at all-ones. Rises inside PEAK only affect pileup. lost_count clears only on reset.
- Mid-operation: enable changes outside ARMED take effect at the DEAD exit. Reset in any state aborts immediately; a pending record is discarded.
- Arithmetic: all signed, width SIZE_FILTER_DATA; no saturation needed (compare and copy only).

Optional Feature:
- Macro: V1_TRIG_BASELINE_EN.
- Defined:
  - In ARMED, a running 16-sample sum of filter_data is kept, width SIZE_FILTER_DATA+4; baseline = sum >>> 4.
  - The baseline is frozen at the rise; event_amp = max - baseline, saturated to the signed SIZE_FILTER_DATA range.
  - On entry to ARMED the sum and sample count restart; before 16 samples have been seen, baseline = 0.
- Undefined: event_amp = max; no baseline logic is built.

Decomposition:
- v1_parameters package gains:
  - typedef enum logic [2:0] {TRG_IDLE, TRG_ARMED, TRG_PEAK, TRG_HOLD, TRG_DEAD} trg_state_t;
  - typedef struct packed event_rec_t {amp, ts, pileup};
  - constants PEAK_WIN_DEF and DEAD_TIME_DEF.
- SIZE_FILTER_DATA is taken from package_settings.
- One sub-module, v1_trig_baseline: 16-deep sample delay line plus running-sum accumulator, instantiated only under V1_TRIG_BASELINE_EN.

Test Plan:
- Single pulse: threshold=100; filter_data 0,50,150,300,420,380,200,0…; PEAK_WIN=16; crossing at ts=T -> event_valid at T+16; amp=420; ts=T; pileup=0.
- Backpressure: hold event_ready=0 for 10 cycles -> record stable and valid=1 throughout; one transfer on ready=1; then exactly DEAD_TIME cycles before a rise is accepted again.
- Pile-up: second pulse re-crosses 100 after dropping to 40 inside the window -> pileup=1; amp = larger of the two peaks.
- Lost triggers: 3 pulses during DEAD -> lost_count=3. Force 70000 crossings -> lost_count saturates at 0xFFFF.
- Enable: enable=0 in ARMED -> no event. enable=0 during PEAK -> event still delivered, then IDLE after DEAD. Reset asserted in HOLD -> event_valid=0 immediately.
- Baseline (V1_TRIG_BASELINE_EN): constant 20 for 16+ cycles, then peak 420 -> amp=400. Without the macro -> amp=420.

Source files
------------

// File: rtl/package_settings.sv
// Shared data-path sizing for the v1 acquisition chain.
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v1_parameters.sv
// Trigger controller types, defaults and the saturating amplitude helper.
package v1_parameters;
  import package_settings::*;

  localparam int PEAK_WIN_DEF  = 16;
  localparam int DEAD_TIME_DEF = 32;
  localparam int TS_W_DEF      = 32;

  typedef enum logic [2:0] {TRG_IDLE, TRG_ARMED, TRG_PEAK, TRG_HOLD, TRG_DEAD} trg_state_t;

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amp;
    logic [TS_W_DEF-1:0]                ts;
    logic                               pileup;
  } event_rec_t;

  // a - b clipped to the signed sample range
  function automatic logic signed [SIZE_FILTER_DATA-1:0] sat_sub(
    input logic signed [SIZE_FILTER_DATA-1:0] a,
    input logic signed [SIZE_FILTER_DATA-1:0] b
  );
    logic signed [SIZE_FILTER_DATA:0] d;
    d = $signed({a[SIZE_FILTER_DATA-1], a}) - $signed({b[SIZE_FILTER_DATA-1], b});
    if (d[SIZE_FILTER_DATA] != d[SIZE_FILTER_DATA-1])
      sat_sub = d[SIZE_FILTER_DATA] ? {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}}
                                    : {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};
    else
      sat_sub = d[SIZE_FILTER_DATA-1:0];
  endfunction
endpackage

// File: rtl/v1_trig_baseline.sv
// Running 16-sample sum of the filter output; baseline = sum/16 once 16 samples are in, else 0.
// One cycle from sample to sum; no backpressure, clear restarts the sum and sample count.
module v1_trig_baseline
  import package_settings::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic signed [SIZE_FILTER_DATA-1:0] sample,
  output logic signed [SIZE_FILTER_DATA-1:0] baseline
);
  localparam int DW = SIZE_FILTER_DATA;

  logic signed [DW-1:0] line [16];
  logic signed [DW+3:0] sum;
  logic [4:0]           count;
  logic                 full;

  assign full     = count[4];
  assign baseline = full ? sum[DW+3:4] : '0;

  // Delay-line contents are only consumed once count shows 16 fresh samples.
  always_ff @(posedge clk) begin
    if (!clear) begin
      line[0] <= sample;
      for (int i = 1; i < 16; i++) line[i] <= line[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum   <= '0;
      count <= '0;
    end else if (clear) begin
      sum   <= '0;
      count <= '0;
    end else begin
      sum <= sum + $signed({{4{sample[DW-1]}}, sample})
                 - (full ? $signed({{4{line[15][DW-1]}}, line[15]}) : $signed((DW+4)'(0)));
      if (!full) count <= count + 5'd1;
    end
  end
endmodule

// File: rtl/v1_filter_trigger_ctrl.sv
// Threshold trigger, peak search and pile-up flag behind the v1 filter; record valid PEAK_WIN cycles after the crossing.
// Record held under valid/ready backpressure, then DEAD_TIME cycles of dead time; V1_TRIG_BASELINE_EN adds baseline subtraction.
module v1_filter_trigger_ctrl
  import package_settings::*;
  import v1_parameters::*;
#(
  parameter int PEAK_WIN  = PEAK_WIN_DEF,
  parameter int DEAD_TIME = DEAD_TIME_DEF,
  parameter int TS_W      = TS_W_DEF,
  parameter int LOST_W    = 16
) (
  input  logic                               reset,
  input  logic                               clk,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                               event_valid,
  input  logic                               event_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] event_amp,
  output logic [TS_W-1:0]                    event_ts,
  output logic                               event_pileup,
  output logic                               busy,
  output logic [LOST_W-1:0]                  lost_count
);
  localparam int DW = SIZE_FILTER_DATA;

  trg_state_t           state, state_nxt;
  logic [TS_W-1:0]      ts_cnt, ts_cap;
  logic signed [DW-1:0] prev_sample, max_q;
  logic [7:0]           win_cnt;
  logic [9:0]           dead_cnt;
  logic                 pileup_q, below_q;
  logic                 rise, window_done, dead_done;

  assign rise        = (filter_data > threshold) && (prev_sample <= threshold);
  assign window_done = (win_cnt == 8'(PEAK_WIN - 1));
  assign dead_done   = (dead_cnt == 10'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TRG_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TRG_IDLE:  if (enable) state_nxt = TRG_ARMED;
      TRG_ARMED: if (rise) state_nxt = TRG_PEAK;
                 else if (!enable) state_nxt = TRG_IDLE;
      TRG_PEAK:  if (window_done) state_nxt = TRG_HOLD;
      TRG_HOLD:  if (event_ready) state_nxt = TRG_DEAD;
      TRG_DEAD:  if (dead_done) state_nxt = enable ? TRG_ARMED : TRG_IDLE;
      default:   state_nxt = TRG_IDLE;
    endcase
  end

  always_comb begin
    event_valid = (state == TRG_HOLD);
    busy        = (state == TRG_PEAK) || (state == TRG_HOLD) || (state == TRG_DEAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt      <= '0;
      prev_sample <= '0;
      ts_cap      <= '0;
      max_q       <= '0;
      win_cnt     <= '0;
      dead_cnt    <= '0;
      pileup_q    <= 1'b0;
      below_q     <= 1'b0;
      lost_count  <= '0;
    end else begin
      ts_cnt      <= ts_cnt + 1'b1;
      prev_sample <= filter_data;
      case (state)
        TRG_ARMED: if (rise) begin
          max_q    <= filter_data;
          ts_cap   <= ts_cnt;
          win_cnt  <= 8'd1;
          pileup_q <= 1'b0;
          below_q  <= 1'b0;
        end
        TRG_PEAK: begin
          if (filter_data > max_q) max_q <= filter_data;
          if (filter_data <= threshold) below_q <= 1'b1;
          // only a re-crossing after the pulse dropped back counts as pile-up
          if (below_q && rise) pileup_q <= 1'b1;
          win_cnt <= win_cnt + 8'd1;
        end
        TRG_HOLD: if (event_ready) dead_cnt <= 10'(DEAD_TIME);
        TRG_DEAD: dead_cnt <= dead_cnt - 10'd1;
        default: ;
      endcase
      if ((state == TRG_HOLD || state == TRG_DEAD) && rise && !(&lost_count))
        lost_count <= lost_count + 1'b1;
    end
  end

  assign event_ts     = ts_cap;
  assign event_pileup = pileup_q;

`ifdef V1_TRIG_BASELINE_EN
  logic signed [DW-1:0] baseline, base_frz;

  v1_trig_baseline u_baseline (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != TRG_ARMED),
    .sample   (filter_data),
    .baseline (baseline)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) base_frz <= '0;
    else if (state == TRG_ARMED && rise) base_frz <= baseline;
  end

  assign event_amp = sat_sub(max_q, base_frz);
`else
  assign event_amp = max_q;
`endif
endmodule

// File: tb/tb_v1_filter_trigger_ctrl.sv
// Directed bench for v1_filter_trigger_ctrl with an expected-record scoreboard.
module tb_v1_filter_trigger_ctrl;
  import package_settings::*;

  localparam int DW  = SIZE_FILTER_DATA;
  localparam int PW  = 16;
  localparam int DT  = 32;
  localparam int TSW = 32;
  localparam int LW  = 12;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b0;
  logic                 event_ready = 1'b0;
  logic signed [DW-1:0] threshold = 100;
  logic signed [DW-1:0] filter_data = 0;
  logic                 event_valid, event_pileup, busy;
  logic signed [DW-1:0] event_amp;
  logic [TSW-1:0]       event_ts;
  logic [LW-1:0]        lost_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic signed [DW-1:0] amp;
    logic [TSW-1:0]       ts;
    logic                 pileup;
  } exp_t;
  exp_t sb[$];

  logic [TSW-1:0] cyc;
  logic [LW-1:0]  lost_all_ones = '1;

  v1_filter_trigger_ctrl #(
    .PEAK_WIN(PW), .DEAD_TIME(DT), .TS_W(TSW), .LOST_W(LW)
  ) dut (
    .reset        (reset),
    .clk          (clk),
    .enable       (enable),
    .threshold    (threshold),
    .filter_data  (filter_data),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_amp    (event_amp),
    .event_ts     (event_ts),
    .event_pileup (event_pileup),
    .busy         (busy),
    .lost_count   (lost_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [DW-1:0] v);
    filter_data = v;
    step();
  endtask

  task automatic push_exp(input logic signed [DW-1:0] amp, input logic pileup);
    exp_t e;
    e.amp = amp;
    e.ts = cyc;
    e.pileup = pileup;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !event_valid; i++) step();
    chk("valid_seen", event_valid, 1);
    if (sb.size() > 0) chk("latency", cyc - sb[0].ts, PW);
  endtask

  task automatic handshake();
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
  endtask

  // Every valid cycle is compared against the oldest expected record.
  always @(negedge clk) begin
    if (reset && event_valid) begin
      chk("event_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        chk("amp", event_amp, sb[0].amp);
        chk("ts", event_ts, sb[0].ts);
        chk("pileup", event_pileup, sb[0].pileup);
        if (event_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", event_valid, 0);
    chk("rst_amp", event_amp, 0);
    chk("rst_ts", event_ts, 0);
    chk("rst_pileup", event_pileup, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lost", lost_count, 0);
    reset = 1'b1;
    step();

    // Arm, then drop enable while ARMED: a later pulse must not trigger.
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    drive(200);
    repeat (25) drive(0);
    chk("idle_busy", busy, 0);
    chk("idle_lost", lost_count, 0);

    // Single pulse with 10 cycles of backpressure.
    enable = 1'b1;
    drive(0); drive(0); drive(50);
    push_exp(420, 1'b0);
    drive(150); drive(300); drive(420); drive(380); drive(200); drive(0);
    wait_valid(40);
    repeat (10) begin
      step();
      chk("bp_valid", event_valid, 1);
      chk("bp_busy", busy, 1);
    end
    handshake();
    chk("post_xfer_valid", event_valid, 0);
    // Rise on the last dead cycle is lost; the block is re-armed right after.
    repeat (DT - 1) drive(0);
    drive(200);
    chk("dead_edge_lost", lost_count, 1);
    chk("rearm_busy", busy, 0);
    repeat (3) drive(0);

    // Pile-up: drop to 40 inside the window and re-cross.
    push_exp(500, 1'b1);
    drive(150); drive(300); drive(40); drive(200); drive(500); drive(100); drive(0);
    wait_valid(40);
    handshake();
    repeat (3) begin
      drive(0);
      drive(200);
    end
    repeat (DT - 6) drive(0);
    chk("lost_three", lost_count, 4);
    chk("dead_exit_busy", busy, 0);

    // Crossing on the first re-armed cycle is accepted; enable drops during PEAK.
    push_exp(150, 1'b0);
    drive(150);
    enable = 1'b0;
    drive(0);
    wait_valid(40);
    handshake();
    repeat (DT) drive(0);
    chk("idle_after_dead_busy", busy, 0);
    drive(200);
    repeat (25) drive(0);
    chk("idle_after_dead_busy2", busy, 0);
    chk("idle_after_dead_lost", lost_count, 4);

    // Flat 20 baseline before a 420 peak.
    enable = 1'b1;
    repeat (20) drive(20);
`ifdef V1_TRIG_BASELINE_EN
    push_exp(400, 1'b0);
`else
    push_exp(420, 1'b0);
`endif
    drive(420);
    repeat (5) drive(20);
    wait_valid(40);
    handshake();
    repeat (DT + 2) drive(0);

    // Reset while a record is pending.
    drive(0); drive(0);
    push_exp(300, 1'b0);
    drive(300);
    drive(0);
    wait_valid(40);
    reset = 1'b0;
    #1;
    chk("rst_hold_valid", event_valid, 0);
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_lost", lost_count, 0);
    chk("rst_hold_amp", event_amp, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Saturate the lost counter with rises while the record is held.
    repeat (3) drive(0);
    push_exp(200, 1'b0);
    drive(200);
    drive(0);
    wait_valid(40);
    repeat (LW * 0 + 4100) begin
      drive(200);
      drive(0);
    end
    chk("lost_sat", lost_count, lost_all_ones);
    chk("sat_valid", event_valid, 1);
    handshake();
    repeat (DT + 2) drive(0);
    chk("lost_sat_hold", lost_count, lost_all_ones);
    chk("sb_empty", sb.size(), 0);
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
